mem_arbiter: RTL
================

# mem_arbiter

- Two-port arbiter and sequencer for the 32 × 14-bit single-port scratch memory.
- Shares the memory's one read/write port between requesters A and B using round-robin priority.
- Provides a clear sequencer that zero-fills all 32 words.
- Sits directly in front of `memoria`: it drives that block's `en`/`address`/`datain` and samples its combinational `dataout`.

## Interface
Parameters:
- AW, 5, address width
- DW, 14, data width
- DEPTH, 32, words cleared by the clear sequence (= 2^AW)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- a_req  in  1  requester A access request (level, held until a_gnt)
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  AW  A address
- a_wdata  in  DW  A write data
- a_gnt  out  1  one-cycle pulse: A's access is executing this cycle
- a_rvalid  out  1  one-cycle pulse: rdata holds A's read result
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid: same as the A ports, for requester B
- rdata  out  DW  registered read data shared by A and B
- clr_start  in  1  clear request (level, held until clr_busy)
- clr_busy  out  1  high while the clear sequence runs
- clr_done  out  1  one-cycle pulse after the last clear write
- mem_en  out  1  memory write enable
- mem_address  out  AW  memory address
- mem_datain  out  DW  memory write data
- mem_dataout  in  DW  memory combinational read data

## Operation
- States:
  - IDLE
  - ACCESS (one cycle)
  - CLEAR (DEPTH cycles)
- Priority pointer `ptr` (0 = A, 1 = B):
  - Reset value 0.
  - After each granted access it points to the other requester, whichever was granted.
- IDLE, evaluated in priority order:
  - If clr_start = 1: go to CLEAR, counter = 0. Clear wins over any pending req.
  - Else, if exactly one req is high: latch that requester's we/addr/wdata and owner, then go to ACCESS.
  - Else, if both reqs are high: the requester selected by `ptr` wins; latch its signals, go to ACCESS.
  - Else: stay in IDLE.
- ACCESS:
  - mem_address = latched addr.
  - mem_en = latched we.
  - mem_datain = latched wdata.
  - Owner's gnt = 1.
  - On a read, rdata <= mem_dataout at the end of the cycle.
  - Next state is always IDLE.
- Read result:
  - The owner's rvalid pulses in the cycle after ACCESS.
  - rdata holds its value until the next read completes.
  - A write updates neither rdata nor rvalid.
- CLEAR:
  - Each cycle: mem_en = 1, mem_address = counter, mem_datain = 0.
  - Counter increments 0..DEPTH-1 with no wrap.
  - After the write to DEPTH-1: go to IDLE and pulse clr_done for 1 cycle; that cycle is in IDLE.
  - clr_busy = 1 in every CLEAR cycle.
  - Reqs are neither sampled nor granted during CLEAR. They stay pending and are arbitrated normally once back in IDLE.
- clr_start is sampled only in IDLE; it is ignored while in ACCESS or CLEAR.
- Outside ACCESS-write and CLEAR, mem_en = 0. mem_address/mem_datain are don't-care there, but must not glitch mem_en.
- Requester obligations:
  - Hold req, we, addr and wdata stable from req assertion through the gnt cycle.
  - Deassert req in the cycle after gnt unless a new access is wanted.
  - A req still high in the cycle after gnt is a new request.

## Timing
- Reset values: state IDLE, ptr = 0, counter = 0. a_gnt, b_gnt, a_rvalid, b_rvalid, clr_busy, clr_done, mem_en and rdata are all 0.
- Reset mid-CLEAR: the sequence is abandoned with no clr_done. Memory is left partially cleared; no retry.
- Reset mid-ACCESS: the write (if any) may or may not land. No rvalid follows.
- Latency: req sampled high in IDLE at edge N → gnt in cycle N+1 → rvalid in cycle N+2.
- Throughput: at most one access per 2 cycles (IDLE/ACCESS alternate).
- Clear sequence:
  - clr_start high in IDLE at cycle N → clr_busy in cycles N+1..N+32.
  - clr_done in cycle N+33, during which pending reqs are also sampled.
- The memory writes on the same clock edge that ends the ACCESS/CLEAR cycle.
- Memory reads are combinational, so a read in ACCESS sees all earlier writes.

## Test plan
- **Reset:** assert rst for 2 cycles with all reqs high → all outputs 0, no gnt during reset; first gnt goes to A two cycles after rst falls.
- **Single read:** A reads addr 5 preloaded with 0x1ABC → a_gnt 1 cycle after req; a_rvalid the following cycle with rdata = 0x1ABC; b_gnt stays 0.
- **Contention:** A and B both hold read reqs continuously → grants alternate A, B, A, B, each 2 cycles apart; each rvalid carries the correct word.
- **Write then read:** B writes 0x0F0F to addr 31, then A reads addr 31 → rdata = 0x0F0F; no rvalid for the write.
- **Clear:** clr_start with A req held high → 32 cycles of mem_en = 1 at addresses 0..31 with data 0; a_gnt withheld; clr_done pulse; a_gnt 1 cycle later; reading any address returns 0.
- **Reset mid-clear:** assert rst at counter = 10 → no clr_done; addr 0..9 read 0, addr 10..31 keep their prior contents; arbiter returns to IDLE with ptr = 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the clear handshake and the scratch-memory port.
// The arbiter takes the slave view; the requesters and the memory take the master view.
interface mem_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 14
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;

  logic [DW-1:0] rdata;

  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;

  logic          mem_en;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_datain;
  logic [DW-1:0] mem_dataout;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  clr_start, mem_dataout,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata,
    output clr_busy, clr_done,
    output mem_en, mem_address, mem_datain
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output clr_start, mem_dataout,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata,
    input  clr_busy, clr_done,
    input  mem_en, mem_address, mem_datain
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two requesters sharing one single-port scratch memory,
// plus a clear sequencer that zero-fills every word.
module mem_arbiter #(
  parameter int AW    = 5,
  parameter int DW    = 14,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    CLEAR  = 2'd2
  } state_e;

  // Access captured in IDLE and replayed on the memory port during ACCESS.
  typedef struct packed {
    logic          owner;  // 0 = A, 1 = B
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_q,    state_d;
  logic          ptr_q,      ptr_d;
  logic [AW-1:0] cnt_q,      cnt_d;
  acc_t          acc_q,      acc_d;
  logic [DW-1:0] rdata_q,    rdata_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic          clr_done_q, clr_done_d;

  logic          pick_b;

  // B wins when it is the only requester, or when both ask and the pointer favours B.
  assign pick_b = bus.b_req && (!bus.a_req || ptr_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      clr_done_q <= clr_done_d;
    end
  end

  // NOTE: the latched access is pure datapath; it is only observed in ACCESS,
  // which is always preceded by a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rdata_d    = rdata_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    clr_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (bus.a_req || bus.b_req) begin
          state_d = ACCESS;
          if (pick_b) begin
            acc_d = acc_t'{owner: 1'b1, we: bus.b_we, addr: bus.b_addr, wdata: bus.b_wdata};
          end else begin
            acc_d = acc_t'{owner: 1'b0, we: bus.a_we, addr: bus.a_addr, wdata: bus.a_wdata};
          end
        end
      end

      ACCESS: begin
        state_d = IDLE;
        ptr_d   = ~acc_q.owner;
        if (!acc_q.we) begin
          rdata_d    = bus.mem_dataout;
          a_rvalid_d = ~acc_q.owner;
          b_rvalid_d = acc_q.owner;
        end
      end

      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.a_gnt       = 1'b0;
    bus.b_gnt       = 1'b0;
    bus.clr_busy    = 1'b0;
    bus.mem_en      = 1'b0;
    bus.mem_address = acc_q.addr;
    bus.mem_datain  = acc_q.wdata;

    unique case (state_q)
      ACCESS: begin
        bus.a_gnt  = ~acc_q.owner;
        bus.b_gnt  = acc_q.owner;
        bus.mem_en = acc_q.we;
      end
      CLEAR: begin
        bus.clr_busy    = 1'b1;
        bus.mem_en      = 1'b1;
        bus.mem_address = cnt_q;
        bus.mem_datain  = '0;
      end
      default: ;
    endcase

    // Reset blocks strobes in the very cycle it is asserted, so an aborted clear
    // stops before writing the word it had reached.
    if (rst) begin
      bus.a_gnt    = 1'b0;
      bus.b_gnt    = 1'b0;
      bus.clr_busy = 1'b0;
      bus.mem_en   = 1'b0;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.clr_done = clr_done_q;

endmodule
